// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared types for the data-hazard unit of the 5-stage RISC-V pipeline.
//   fwd_sel_e  : operand source chosen for one read port (RF / EX-MEM / MEM-WB)
//   hz_state_e : load-use stall FSM states
//   REG_X0     : architectural zero register index, never forwarded or hazarded
// ---------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  typedef enum logic [0:0] {
    HZ_RUN   = 1'b0,
    HZ_STALL = 1'b1
  } hz_state_e;

  localparam int unsigned REG_X0 = 32'd0;

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_fwd_ctrl_if
// Bundle between the pipeline registers / PC enables and the hazard unit.
//   Pipeline -> unit : rs_id, rs_ex, rd_ex/regwrite_ex/memread_ex,
//                      rd_mem/regwrite_mem/memread_mem, rd_wb/regwrite_wb,
//                      mem_ready, flush
//   Unit -> pipeline : fwd_sel (2 bits per read port), stall_if, stall_id,
//                      bubble_ex, freeze, stall_cnt
//   master = pipeline side, slave = hazard unit.
// ---------------------------------------------------------------------------
interface hazard_fwd_ctrl_if #(
  parameter int NREAD  = 2,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);

  logic [NREAD*REG_AW-1:0] rs_id;
  logic [NREAD*REG_AW-1:0] rs_ex;
  logic [REG_AW-1:0]       rd_ex;
  logic                    regwrite_ex;
  logic                    memread_ex;
  logic [REG_AW-1:0]       rd_mem;
  logic                    regwrite_mem;
  logic                    memread_mem;
  logic [REG_AW-1:0]       rd_wb;
  logic                    regwrite_wb;
  logic                    mem_ready;
  logic                    flush;

  logic [NREAD*2-1:0]      fwd_sel;
  logic                    stall_if;
  logic                    stall_id;
  logic                    bubble_ex;
  logic                    freeze;
  logic [CNT_W-1:0]        stall_cnt;

  modport master (
    output rs_id, rs_ex, rd_ex, regwrite_ex, memread_ex,
           rd_mem, regwrite_mem, memread_mem, rd_wb, regwrite_wb,
           mem_ready, flush,
    input  fwd_sel, stall_if, stall_id, bubble_ex, freeze, stall_cnt
  );

  modport slave (
    input  rs_id, rs_ex, rd_ex, regwrite_ex, memread_ex,
           rd_mem, regwrite_mem, memread_mem, rd_wb, regwrite_wb,
           mem_ready, flush,
    output fwd_sel, stall_if, stall_id, bubble_ex, freeze, stall_cnt
  );

endinterface

// File: rtl/fwd_port_sel.sv
// ---------------------------------------------------------------------------
// fwd_port_sel
// Forwarding source for a single read port of the instruction in EX.
//   rs_i                          : source register of this port
//   rd_mem_i / regwrite_mem_i /
//   memread_mem_i                 : producer currently in MEM
//   rd_wb_i / regwrite_wb_i       : producer currently in WB
//   sel_o                         : FWD_RF, FWD_EXMEM or FWD_MEMWB
// ---------------------------------------------------------------------------
module fwd_port_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] rd_mem_i,
  input  logic              regwrite_mem_i,
  input  logic              memread_mem_i,
  input  logic [REG_AW-1:0] rd_wb_i,
  input  logic              regwrite_wb_i,
  output fwd_sel_e          sel_o
);

  // Priority compare: x0 reads RF, nearest producer wins; a load sitting in
  // MEM has no data yet in EX/MEM, so it falls through to the WB check.
  always_comb begin
    sel_o = FWD_RF;
    if (rs_i == REG_AW'(REG_X0)) begin
      sel_o = FWD_RF;
    end else if (regwrite_mem_i && !memread_mem_i && (rd_mem_i == rs_i)) begin
      sel_o = FWD_EXMEM;
    end else if (regwrite_wb_i && (rd_wb_i == rs_i)) begin
      sel_o = FWD_MEMWB;
    end else begin
      sel_o = FWD_RF;
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_fwd_ctrl
// Data-hazard unit: operand forwarding select, load-use stall FSM, memory-wait
// freeze and a saturating stall-cycle counter.
//   clk    : all state updates on the rising edge
//   reset  : synchronous, active-high; forces every output to 0
//   bus    : hazard_fwd_ctrl_if.slave (pipeline fields in, control out)
// Parameters: NREAD read ports, REG_AW register address width, LOAD_LAT
// load-use stall cycles (>=1), CNT_W stall counter width.
// ---------------------------------------------------------------------------
module hazard_fwd_ctrl
  import hazard_pkg::*;
#(
  parameter int NREAD    = 2,
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  hazard_fwd_ctrl_if.slave      bus
);

  localparam int REM_W = $clog2(LOAD_LAT + 1);

  localparam logic [0:0] S_RUN   = HZ_RUN;
  localparam logic [0:0] S_STALL = HZ_STALL;

  logic [0:0]         state_q, state_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               lu_s;
  logic               freeze_s;
  logic               stall_s;
  logic               bubble_s;
  fwd_sel_e           sel_s [NREAD];
  logic [NREAD*2-1:0] fwd_s;

  // One priority selector per read port of the EX instruction
  for (genvar g = 0; g < NREAD; g++) begin : g_port
    fwd_port_sel #(
      .REG_AW         (REG_AW)
    ) u_sel (
      .rs_i           (bus.rs_ex[g*REG_AW +: REG_AW]),
      .rd_mem_i       (bus.rd_mem),
      .regwrite_mem_i (bus.regwrite_mem),
      .memread_mem_i  (bus.memread_mem),
      .rd_wb_i        (bus.rd_wb),
      .regwrite_wb_i  (bus.regwrite_wb),
      .sel_o          (sel_s[g])
    );
  end

  // Pack per-port selects; everything reads as RF while in reset
  always_comb begin
    fwd_s = '0;
    for (int i = 0; i < NREAD; i++) begin
      fwd_s[i*2 +: 2] = reset ? 2'b00 : 2'(sel_s[i]);
    end
  end

  // Load-use: a load in EX writing a non-zero register read by ID
  always_comb begin
    lu_s = 1'b0;
    for (int i = 0; i < NREAD; i++) begin
      lu_s = lu_s | (bus.rs_id[i*REG_AW +: REG_AW] == bus.rd_ex);
    end
    lu_s = lu_s & bus.memread_ex & bus.regwrite_ex & (bus.rd_ex != REG_AW'(REG_X0));
  end

  assign freeze_s = bus.memread_mem & ~bus.mem_ready;

  // Stall FSM next state: freeze holds everything, flush cancels any stall,
  // otherwise RUN starts a stall on lu and STALL counts rem down to zero
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    stall_s  = 1'b0;
    bubble_s = 1'b0;
    if (freeze_s) begin
      stall_s  = 1'b1;
      bubble_s = 1'b0;
    end else if (bus.flush) begin
      state_d  = S_RUN;
      rem_d    = '0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (lu_s) begin
            stall_s  = 1'b1;
            bubble_s = 1'b1;
            // The first stall cycle is spent in RUN; STALL covers the rest
            if (LOAD_LAT > 1) begin
              state_d = S_STALL;
              rem_d   = REM_W'(LOAD_LAT - 1);
            end else begin
              state_d = S_RUN;
              rem_d   = '0;
            end
          end else begin
            state_d = S_RUN;
            rem_d   = '0;
          end
        end
        S_STALL: begin
          stall_s  = 1'b1;
          bubble_s = 1'b1;
          if (rem_q == REM_W'(1)) begin
            state_d = S_RUN;
            rem_d   = '0;
          end else begin
            state_d = S_STALL;
            rem_d   = rem_q - REM_W'(1);
          end
        end
        default: begin
          state_d = S_RUN;
          rem_d   = '0;
        end
      endcase
    end
  end

  // Saturating count of cycles with stall_id asserted
  always_comb begin
    if (stall_s && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State, remaining-stall and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RUN;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.fwd_sel   = fwd_s;
  assign bus.stall_if  = ~reset & stall_s;
  assign bus.stall_id  = ~reset & stall_s;
  assign bus.bubble_ex = ~reset & bubble_s;
  assign bus.freeze    = ~reset & freeze_s;
  assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_fwd_ctrl
// Three hazard units share one stimulus: LOAD_LAT=1, LOAD_LAT=3, and
// LOAD_LAT=3 with a 2-bit stall counter. A reference model tracks, per unit,
// the number of stall cycles still owed and the stall count, and every cycle
// is compared against it; directed sequences add fixed expectations.
// ---------------------------------------------------------------------------
module tb_hazard_fwd_ctrl;

  localparam int NR = 2;
  localparam int AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [9:0]    rs_id, rs_ex;
  logic [4:0]    rd_ex, rd_mem, rd_wb;
  logic          rw_ex, mr_ex, rw_mem, mr_mem, rw_wb, mem_ready, flush;

  logic [3:0]    o_fwd [3];
  logic          o_sif [3];
  logic          o_sid [3];
  logic          o_bub [3];
  logic          o_frz [3];
  int            o_cnt [3];

  hazard_fwd_ctrl_if #(.NREAD(NR), .REG_AW(AW), .CNT_W(16)) b1 ();
  hazard_fwd_ctrl_if #(.NREAD(NR), .REG_AW(AW), .CNT_W(16)) b3 ();
  hazard_fwd_ctrl_if #(.NREAD(NR), .REG_AW(AW), .CNT_W(2))  bs ();

  hazard_fwd_ctrl #(.NREAD(NR), .REG_AW(AW), .LOAD_LAT(1), .CNT_W(16))
    u_d1 (.clk(clk), .reset(rst), .bus(b1.slave));
  hazard_fwd_ctrl #(.NREAD(NR), .REG_AW(AW), .LOAD_LAT(3), .CNT_W(16))
    u_d3 (.clk(clk), .reset(rst), .bus(b3.slave));
  hazard_fwd_ctrl #(.NREAD(NR), .REG_AW(AW), .LOAD_LAT(3), .CNT_W(2))
    u_ds (.clk(clk), .reset(rst), .bus(bs.slave));

  assign b1.rs_id = rs_id;   assign b1.rs_ex = rs_ex;   assign b1.rd_ex = rd_ex;
  assign b1.regwrite_ex = rw_ex;   assign b1.memread_ex = mr_ex;   assign b1.rd_mem = rd_mem;
  assign b1.regwrite_mem = rw_mem; assign b1.memread_mem = mr_mem; assign b1.rd_wb = rd_wb;
  assign b1.regwrite_wb = rw_wb;   assign b1.mem_ready = mem_ready; assign b1.flush = flush;
  assign b3.rs_id = rs_id;   assign b3.rs_ex = rs_ex;   assign b3.rd_ex = rd_ex;
  assign b3.regwrite_ex = rw_ex;   assign b3.memread_ex = mr_ex;   assign b3.rd_mem = rd_mem;
  assign b3.regwrite_mem = rw_mem; assign b3.memread_mem = mr_mem; assign b3.rd_wb = rd_wb;
  assign b3.regwrite_wb = rw_wb;   assign b3.mem_ready = mem_ready; assign b3.flush = flush;
  assign bs.rs_id = rs_id;   assign bs.rs_ex = rs_ex;   assign bs.rd_ex = rd_ex;
  assign bs.regwrite_ex = rw_ex;   assign bs.memread_ex = mr_ex;   assign bs.rd_mem = rd_mem;
  assign bs.regwrite_mem = rw_mem; assign bs.memread_mem = mr_mem; assign bs.rd_wb = rd_wb;
  assign bs.regwrite_wb = rw_wb;   assign bs.mem_ready = mem_ready; assign bs.flush = flush;

  assign o_fwd[0] = b1.fwd_sel;  assign o_fwd[1] = b3.fwd_sel;  assign o_fwd[2] = bs.fwd_sel;
  assign o_sif[0] = b1.stall_if; assign o_sif[1] = b3.stall_if; assign o_sif[2] = bs.stall_if;
  assign o_sid[0] = b1.stall_id; assign o_sid[1] = b3.stall_id; assign o_sid[2] = bs.stall_id;
  assign o_bub[0] = b1.bubble_ex; assign o_bub[1] = b3.bubble_ex; assign o_bub[2] = bs.bubble_ex;
  assign o_frz[0] = b1.freeze;   assign o_frz[1] = b3.freeze;   assign o_frz[2] = bs.freeze;
  assign o_cnt[0] = int'(b1.stall_cnt);
  assign o_cnt[1] = int'(b3.stall_cnt);
  assign o_cnt[2] = int'(bs.stall_cnt);

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model state: stall cycles still owed after the current one,
  // and the stall count each unit should currently show
  int m_lat  [3] = '{1, 3, 3};
  int m_max  [3] = '{65535, 65535, 3};
  int m_left [3] = '{0, 0, 0};
  int m_cnt  [3] = '{0, 0, 0};

  typedef struct packed {
    logic [9:0] rs_ex;
    logic [4:0] rd_mem;
    logic       rw_mem;
    logic       mr_mem;
    logic [4:0] rd_wb;
    logic       rw_wb;
    logic [3:0] exp;
  } fwd_vec_t;

  fwd_vec_t tab [9];

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] fwd_model();
    logic [3:0] r;
    logic [4:0] rs;
    r = 4'd0;
    if (!rst) begin
      for (int p = 0; p < 2; p++) begin
        rs = rs_ex[p*5 +: 5];
        if (rs != 5'd0) begin
          if (rw_mem && !mr_mem && (rd_mem == rs)) r[p*2 +: 2] = 2'b01;
          else if (rw_wb && (rd_wb == rs))         r[p*2 +: 2] = 2'b10;
        end
      end
    end
    return r;
  endfunction

  task automatic model_cycle();
    logic lu, frz, s, b;
    logic [3:0] ef;
    lu  = mr_ex && rw_ex && (rd_ex != 5'd0) &&
          ((rd_ex == rs_id[4:0]) || (rd_ex == rs_id[9:5]));
    frz = mr_mem && !mem_ready;
    ef  = fwd_model();
    for (int k = 0; k < 3; k++) begin
      if (rst)                          begin s = 1'b0; b = 1'b0; end
      else if (frz)                     begin s = 1'b1; b = 1'b0; end
      else if (flush)                   begin s = 1'b0; b = 1'b0; end
      else if ((m_left[k] > 0) || lu)   begin s = 1'b1; b = 1'b1; end
      else                              begin s = 1'b0; b = 1'b0; end
      chk($sformatf("fwd_sel[%0d]", k),   o_fwd[k], ef);
      chk($sformatf("stall_if[%0d]", k),  o_sif[k], s);
      chk($sformatf("stall_id[%0d]", k),  o_sid[k], s);
      chk($sformatf("bubble_ex[%0d]", k), o_bub[k], b);
      chk($sformatf("freeze[%0d]", k),    o_frz[k], !rst && frz);
      chk($sformatf("stall_cnt[%0d]", k), o_cnt[k], m_cnt[k]);
      if (rst) begin
        m_left[k] = 0;
        m_cnt[k]  = 0;
      end else begin
        if (s && (m_cnt[k] < m_max[k])) m_cnt[k]++;
        if (frz)                m_left[k] = m_left[k];
        else if (flush)         m_left[k] = 0;
        else if (m_left[k] > 0) m_left[k]--;
        else if (lu)            m_left[k] = m_lat[k] - 1;
      end
    end
  endtask

  task automatic eval_cycle();
    @(negedge clk);
    model_cycle();
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs_id = 10'd0; rs_ex = 10'd0; rd_ex = 5'd0; rd_mem = 5'd0; rd_wb = 5'd0;
    rw_ex = 1'b0; mr_ex = 1'b0; rw_mem = 1'b0; mr_mem = 1'b0; rw_wb = 1'b0;
    mem_ready = 1'b1; flush = 1'b0;
  endtask

  task automatic set_lu();
    mr_ex = 1'b1; rw_ex = 1'b1; rd_ex = 5'd3; rs_id = {5'd3, 5'd1};
  endtask

  task automatic reset_pulse();
    rst = 1'b1; idle(); eval_cycle(); next_cycle(); rst = 1'b0;
  endtask

  initial begin
    tab[0] = '{{5'd5, 5'd5},  5'd5,  1'b1, 1'b0, 5'd0,  1'b0, 4'b0101};
    tab[1] = '{{5'd0, 5'd7},  5'd7,  1'b1, 1'b0, 5'd7,  1'b1, 4'b0001};
    tab[2] = '{{5'd0, 5'd0},  5'd0,  1'b1, 1'b0, 5'd0,  1'b1, 4'b0000};
    tab[3] = '{{5'd3, 5'd3},  5'd3,  1'b1, 1'b1, 5'd3,  1'b1, 4'b1010};
    tab[4] = '{{5'd3, 5'd3},  5'd3,  1'b1, 1'b1, 5'd4,  1'b1, 4'b0000};
    tab[5] = '{{5'd9, 5'd2},  5'd9,  1'b0, 1'b0, 5'd9,  1'b1, 4'b1000};
    tab[6] = '{{5'd4, 5'd6},  5'd6,  1'b1, 1'b0, 5'd4,  1'b1, 4'b1001};
    tab[7] = '{{5'd8, 5'd8},  5'd1,  1'b1, 1'b0, 5'd8,  1'b0, 4'b0000};
    tab[8] = '{{5'd31, 5'd31}, 5'd31, 1'b1, 1'b0, 5'd0, 1'b0, 4'b0101};

    rst = 1'b1;
    idle();
    next_cycle();

    // Reset forces all outputs low even with forwarding, freeze and lu present
    rs_ex = {5'd5, 5'd5}; rd_mem = 5'd5; rw_mem = 1'b1; mr_mem = 1'b1; mem_ready = 1'b0;
    set_lu();
    eval_cycle();
    chk("rst_fwd", o_fwd[0], 4'd0);
    chk("rst_stall_id", o_sid[1], 1'b0);
    chk("rst_freeze", o_frz[1], 1'b0);
    chk("rst_cnt", o_cnt[1], 0);
    next_cycle();
    rst = 1'b0;

    // Forwarding table
    for (int i = 0; i < 9; i++) begin
      idle();
      rs_ex = tab[i].rs_ex; rd_mem = tab[i].rd_mem; rw_mem = tab[i].rw_mem;
      mr_mem = tab[i].mr_mem; rd_wb = tab[i].rd_wb; rw_wb = tab[i].rw_wb;
      eval_cycle();
      chk($sformatf("fwd_tab%0d", i), o_fwd[0], tab[i].exp);
      chk($sformatf("fwd_tab%0d_nostall", i), o_sid[0], 1'b0);
      next_cycle();
    end

    // Load-use: one stall cycle at LOAD_LAT=1, three at LOAD_LAT=3
    reset_pulse();
    set_lu();
    eval_cycle();
    chk("lu_c1_sif_d1", o_sif[0], 1'b1); chk("lu_c1_bub_d1", o_bub[0], 1'b1);
    chk("lu_c1_sid_d3", o_sid[1], 1'b1);
    next_cycle();
    idle();
    eval_cycle();
    chk("lu_c2_sid_d1", o_sid[0], 1'b0); chk("lu_c2_bub_d1", o_bub[0], 1'b0);
    chk("lu_c2_sid_d3", o_sid[1], 1'b1);
    next_cycle();
    eval_cycle(); chk("lu_c3_bub_d3", o_bub[1], 1'b1); next_cycle();
    eval_cycle(); chk("lu_c4_sid_d3", o_sid[1], 1'b0); next_cycle();
    eval_cycle();
    chk("lu_cnt_d3", o_cnt[1], 3); chk("lu_cnt_d1", o_cnt[0], 1);
    next_cycle();

    // Memory wait of 4 cycles inside a LOAD_LAT=3 stall
    reset_pulse();
    set_lu(); eval_cycle(); next_cycle();
    idle(); mr_mem = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      eval_cycle();
      chk($sformatf("mw_frz%0d", i), o_frz[1], 1'b1);
      chk($sformatf("mw_bub%0d", i), o_bub[1], 1'b0);
      chk($sformatf("mw_sif%0d", i), o_sif[1], 1'b1);
      next_cycle();
    end
    idle();
    for (int i = 0; i < 2; i++) begin
      eval_cycle(); chk($sformatf("mw_resume%0d", i), o_bub[1], 1'b1); next_cycle();
    end
    eval_cycle();
    chk("mw_done_sid", o_sid[1], 1'b0);
    chk("mw_cnt_d3", o_cnt[1], 7); chk("mw_cnt_d1", o_cnt[0], 5);
    next_cycle();

    // Flush in the second stall cycle, then lu together with flush
    reset_pulse();
    set_lu(); eval_cycle(); next_cycle();
    idle(); flush = 1'b1;
    eval_cycle(); chk("fl_sid", o_sid[1], 1'b0); chk("fl_bub", o_bub[1], 1'b0); next_cycle();
    idle();
    eval_cycle(); chk("fl_next_sid", o_sid[1], 1'b0); chk("fl_next_bub", o_bub[1], 1'b0); next_cycle();
    set_lu(); flush = 1'b1;
    eval_cycle(); chk("fllu_sid_d1", o_sid[0], 1'b0); chk("fllu_sid_d3", o_sid[1], 1'b0); next_cycle();
    idle();
    eval_cycle(); chk("fllu_after_d3", o_sid[1], 1'b0); next_cycle();

    // Reset in the middle of a stall
    reset_pulse();
    set_lu(); eval_cycle(); next_cycle();
    idle();
    eval_cycle(); chk("rs_mid_sid", o_sid[1], 1'b1); next_cycle();
    rst = 1'b1;
    eval_cycle(); chk("rs_sid", o_sid[1], 1'b0); chk("rs_bub", o_bub[1], 1'b0); next_cycle();
    eval_cycle(); chk("rs_cnt", o_cnt[1], 0); next_cycle();
    rst = 1'b0;
    eval_cycle(); chk("rs_run_sid", o_sid[1], 1'b0); next_cycle();

    // Saturation of the 2-bit counter
    reset_pulse();
    set_lu();
    for (int i = 0; i < 5; i++) begin eval_cycle(); next_cycle(); end
    idle();
    for (int i = 0; i < 3; i++) begin eval_cycle(); next_cycle(); end
    eval_cycle();
    chk("sat_cnt_w2", o_cnt[2], 3); chk("sat_cnt_w16", o_cnt[1], 6);
    next_cycle();

    // Randomised traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 63) == 0);
      rs_id     = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      rs_ex     = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      rd_ex     = 5'($urandom_range(0, 3));
      rd_mem    = 5'($urandom_range(0, 3));
      rd_wb     = 5'($urandom_range(0, 3));
      rw_ex     = 1'($urandom_range(0, 1));
      mr_ex     = 1'($urandom_range(0, 1));
      rw_mem    = 1'($urandom_range(0, 1));
      mr_mem    = ($urandom_range(0, 3) == 0);
      rw_wb     = 1'($urandom_range(0, 1));
      mem_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      eval_cycle();
      next_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
